// File: rtl/tone_fifo_synth.sv
// Tone command FIFO feeding a phase-accumulator oscillator with a linear envelope.
// One command is popped per enabled sample tick; samples leave through a two-stage pipeline.
module tone_fifo_synth #(
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int ATTACK_STEP  = 8,
  parameter int RELEASE_STEP = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   tone_in,
  input  logic          ld_fifo,
  input  logic          run,
  input  logic          sample_tick,
  input  logic [1:0]    wave_sel,
  output logic          fifo_full,
  output logic [AW:0]   fifo_count,
  output logic          overflow,
  output logic [15:0]   sample_out,
  output logic          sample_valid
);

  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [31:0]        mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r, rd_ptr_r;
  logic [AW:0]        count_r, count_nxt_s;
  logic               full_r, overflow_r, ld_q_r;
  logic [23:0]        phase_r, inc_r;
  logic [6:0]         amp_r, target_r, amp1_r;
  logic               gate_r, v0_r, v1_r;
  logic signed [7:0]  w_r;
  logic [15:0]        sample_r;
  logic               valid_r;
  logic [31:0]        head_s;
  logic               wr_s, tick_s, pop_s, accept_s;
  logic signed [14:0] prod_s;

  function automatic logic [6:0] env_next(input logic gate, input logic [6:0] amp,
                                          input logic [6:0] tgt);
    logic [7:0] up;
    logic [6:0] res;
    up  = {1'b0, amp} + 8'(ATTACK_STEP);
    res = amp;
    if (gate) begin
      if (amp < tgt) begin
        res = (up > {1'b0, tgt}) ? tgt : up[6:0];
      end else if (amp > tgt) begin
        res = ({1'b0, amp} > ({1'b0, tgt} + 8'(RELEASE_STEP))) ? (amp - 7'(RELEASE_STEP)) : tgt;
      end else begin
        res = amp;
      end
    end else begin
      res = (amp > 7'(RELEASE_STEP)) ? (amp - 7'(RELEASE_STEP)) : 7'd0;
    end
    return res;
  endfunction

  // ph holds phase[23:15]
  function automatic logic signed [7:0] wave_of(input logic [1:0] sel, input logic [8:0] ph);
    logic signed [7:0] w;
    case (sel)
      2'd0:    w = ph[8] ? 8'sh80 : 8'sh7F;
      2'd1:    w = $signed(ph[8:1] ^ 8'h80);
      2'd2:    w = ph[8] ? $signed(~(ph[7:0] ^ 8'h80)) : $signed(ph[7:0] ^ 8'h80);
      default: w = 8'sh00;
    endcase
    return w;
  endfunction

  assign head_s   = mem_r[rd_ptr_r];
  assign wr_s     = ld_fifo & ~ld_q_r;
  assign tick_s   = sample_tick & run;
  assign pop_s    = tick_s & (count_r != {(AW+1){1'b0}});
  assign accept_s = wr_s & ((count_r != FULL_LVL) | pop_s);
  assign prod_s   = w_r * $signed({1'b0, amp1_r});

  // Occupancy after this cycle's write and pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({accept_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_r[wr_ptr_r] <= tone_in;
    end
  end

  // FIFO control, oscillator state and the output pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
      ld_q_r     <= 1'b1;
      phase_r    <= 24'd0;
      amp_r      <= 7'd0;
      gate_r     <= 1'b0;
      target_r   <= 7'd0;
      inc_r      <= 24'd0;
      v0_r       <= 1'b0;
      v1_r       <= 1'b0;
      w_r        <= 8'sd0;
      amp1_r     <= 7'd0;
      sample_r   <= 16'd0;
      valid_r    <= 1'b0;
    end else begin
      ld_q_r  <= ld_fifo;
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == FULL_LVL);
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (wr_s && !accept_s) begin
        overflow_r <= 1'b1;
      end
      if (tick_s) begin
        phase_r <= phase_r + inc_r;
        amp_r   <= env_next(gate_r, amp_r, target_r);
      end
      // The popped command governs the next tick, not this one.
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        gate_r   <= head_s[31];
        target_r <= head_s[30:24];
        inc_r    <= head_s[23:0];
      end
      v0_r     <= tick_s;
      w_r      <= wave_of(wave_sel, phase_r[23:15]);
      amp1_r   <= amp_r;
      v1_r     <= v0_r;
      if (v1_r) begin
        sample_r <= {prod_s, 1'b0};
      end
      valid_r  <= v1_r;
    end
  end

  assign fifo_full    = full_r;
  assign fifo_count   = count_r;
  assign overflow     = overflow_r;
  assign sample_out   = sample_r;
  assign sample_valid = valid_r;

endmodule

// File: tb/tb_tone_fifo_synth.sv
// Self-checking bench for tone_fifo_synth: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_tone_fifo_synth;
  localparam int DEPTH = 16;
  localparam int ATK   = 127;
  localparam int REL   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] tone_in;
  logic        ld_fifo, run, sample_tick;
  logic [1:0]  wave_sel;
  logic        fifo_full, overflow, sample_valid;
  logic [4:0]  fifo_count;
  logic [15:0] sample_out;

  int total = 0;
  int bad   = 0;

  tone_fifo_synth #(.DEPTH(DEPTH), .AW(4), .ATTACK_STEP(ATK), .RELEASE_STEP(REL)) dut (
    .clk(clk), .reset(reset), .tone_in(tone_in), .ld_fifo(ld_fifo), .run(run),
    .sample_tick(sample_tick), .wave_sel(wave_sel), .fifo_full(fifo_full),
    .fifo_count(fifo_count), .overflow(overflow), .sample_out(sample_out),
    .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { int due; int val; } pend_t;
  logic [31:0] mq[$];
  pend_t       pq[$];
  pend_t       pe;
  logic [31:0] word;
  bit m_ld_prev, m_ovf, m_valid, m_gate, m_wr, m_pop;
  int m_phase, m_amp, m_tgt, m_inc, m_cyc, m_sample;

  function automatic int model_wave(input logic [1:0] sel, input int ph);
    int hi8, mid;
    bit top;
    hi8 = (ph >> 16) & 255;
    mid = ((ph >> 15) & 255) - 128;
    top = ((ph >> 23) & 1) != 0;
    case (sel)
      2'd0:    return top ? -128 : 127;
      2'd1:    return hi8 - 128;
      2'd2:    return top ? (-mid - 1) : mid;
      default: return 0;
    endcase
  endfunction

  initial begin
    m_cyc = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mq.delete(); pq.delete();
        m_ld_prev = 1'b1; m_ovf = 1'b0; m_valid = 1'b0; m_sample = 0;
        m_phase = 0; m_amp = 0; m_gate = 1'b0; m_tgt = 0; m_inc = 0;
      end else begin
        m_cyc++;
        m_valid = 1'b0;
        if (pq.size() > 0 && pq[0].due == m_cyc) begin
          m_valid  = 1'b1;
          m_sample = pq[0].val;
          void'(pq.pop_front());
        end
        m_wr = ld_fifo && !m_ld_prev;
        m_ld_prev = ld_fifo;
        m_pop = sample_tick && run && (mq.size() > 0);
        if (sample_tick && run) begin
          m_phase = (m_phase + m_inc) % (1 << 24);
          if (m_gate) begin
            if (m_amp < m_tgt) m_amp = (m_amp + ATK > m_tgt) ? m_tgt : m_amp + ATK;
            else if (m_amp > m_tgt) m_amp = (m_amp - REL < m_tgt) ? m_tgt : m_amp - REL;
          end else begin
            m_amp = (m_amp - REL < 0) ? 0 : m_amp - REL;
          end
          pe.due = m_cyc + 2;
          pe.val = model_wave(wave_sel, m_phase) * m_amp * 2;
          pq.push_back(pe);
        end
        if (m_pop) begin
          word   = mq.pop_front();
          m_gate = word[31];
          m_tgt  = int'(word[30:24]);
          m_inc  = int'(word[23:0]);
        end
        if (m_wr) begin
          if (mq.size() < DEPTH) mq.push_back(tone_in);
          else m_ovf = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("fifo_count", int'(fifo_count), mq.size());
      chk("fifo_full", int'(fifo_full), (mq.size() == DEPTH) ? 1 : 0);
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("sample_valid", int'(sample_valid), int'(m_valid));
      if (m_valid) chk("sample_out", int'($signed(sample_out)), m_sample);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  task automatic write(input logic [31:0] w);
    tone_in = w; ld_fifo = 1'b1;
    step(1);
    ld_fifo = 1'b0;
    step(1);
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
  endtask

  task automatic read_tick(output int s);
    bit got;
    got = 1'b0;
    s = 0;
    tick();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!got && sample_valid) begin
        s = int'($signed(sample_out));
        got = 1'b1;
      end
    end
    if (!got) chk("sample_timeout", 0, 1);
    step(1);
  endtask

  int s2, s3, s4, s255, s256, s257, s258;

  initial begin
    reset = 1'b1; tone_in = 32'd0; ld_fifo = 1'b0; run = 1'b0;
    sample_tick = 1'b0; wave_sel = 2'd0;
    step(3);
    reset = 1'b0;
    step(1);
    @(negedge clk);
    chk("rst_count", int'(fifo_count), 0);
    chk("rst_full", int'(fifo_full), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_sample", int'(sample_out), 0);
    chk("rst_valid", int'(sample_valid), 0);
    step(1);

    // 1: fill, full, overflow
    for (int i = 0; i < 3; i++) write(32'h8100_0100 + 32'(i));
    @(negedge clk);
    chk("t1_count3", int'(fifo_count), 3);
    chk("t1_full3", int'(fifo_full), 0);
    step(1);
    for (int i = 3; i < 16; i++) write(32'h8100_0100 + 32'(i));
    @(negedge clk);
    chk("t1_full16", int'(fifo_full), 1);
    step(1);
    write(32'h1234_5678);
    @(negedge clk);
    chk("t1_count_ovf", int'(fifo_count), 16);
    chk("t1_ovf", int'(overflow), 1);
    step(1);

    // 2: level held high writes once; level across reset writes nothing
    do_reset();
    tone_in = 32'h8500_0010; ld_fifo = 1'b1;
    step(10);
    ld_fifo = 1'b0;
    step(2);
    @(negedge clk);
    chk("t2_once", int'(fifo_count), 1);
    step(1);
    ld_fifo = 1'b1;
    do_reset();
    step(3);
    ld_fifo = 1'b0;
    step(2);
    @(negedge clk);
    chk("t2_thru_reset", int'(fifo_count), 0);
    step(1);

    // 3: square, instant attack
    do_reset();
    wave_sel = 2'd0; run = 1'b1;
    write(32'hFF08_0000);
    tick();
    step(4);
    read_tick(s2);
    chk("t3_square", s2, 32258);

    // 4: saw ramp and wrap
    do_reset();
    wave_sel = 2'd1; run = 1'b1;
    write(32'hFF01_0000);
    tick();
    step(4);
    read_tick(s2);
    read_tick(s3);
    read_tick(s4);
    chk("t4_first", s2, -32258);
    chk("t4_step_a", s3 - s2, 254);
    chk("t4_step_b", s4 - s3, 254);
    sample_tick = 1'b1;
    step(250);
    sample_tick = 1'b0;
    step(4);
    read_tick(s255);
    read_tick(s256);
    read_tick(s257);
    read_tick(s258);
    chk("t4_top", s256, 32258);
    chk("t4_top_step", s256 - s255, 254);
    chk("t4_wrap", s257, -32512);
    chk("t4_after_wrap", s258 - s257, 254);

    // triangle with a falling envelope, exercised through the model
    wave_sel = 2'd2;
    write(32'h0002_0000);
    step(2);
    for (int i = 0; i < 12; i++) begin tick(); step(1); end
    step(4);

    // 5: run=0 freezes ticks
    do_reset();
    wave_sel = 2'd0;
    write(32'h8A00_1000);
    write(32'h9400_2000);
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); step(2); end
    @(negedge clk);
    chk("t5_hold", int'(fifo_count), 2);
    step(1);
    run = 1'b1;
    tick();
    step(3);
    @(negedge clk);
    chk("t5_pop", int'(fifo_count), 1);
    step(1);

    // 6: write+pop when full
    do_reset();
    run = 1'b0;
    for (int i = 0; i < 16; i++) write(32'hFF04_0000 + 32'(i));
    run = 1'b1;
    tone_in = 32'hFF02_0000; ld_fifo = 1'b1; sample_tick = 1'b1;
    step(1);
    ld_fifo = 1'b0; sample_tick = 1'b0;
    @(negedge clk);
    chk("t6_full_count", int'(fifo_count), 16);
    chk("t6_full_ovf", int'(overflow), 0);
    step(1);

    // write+pop when empty
    do_reset();
    run = 1'b1;
    tone_in = 32'hFF04_0000; ld_fifo = 1'b1; sample_tick = 1'b1;
    step(1);
    ld_fifo = 1'b0; sample_tick = 1'b0;
    @(negedge clk);
    chk("t6_empty_count", int'(fifo_count), 1);
    step(1);

    // reset during E+1 discards the in-flight sample
    tick();
    step(1);
    tick();
    step(4);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_rst_valid", int'(sample_valid), 0);
      chk("t6_rst_sample", int'(sample_out), 0);
    end
    step(1);
    reset = 1'b0;
    step(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
